// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, flag bit indices and FSM states shared by the alu_seq files
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SUBC = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_LSRA = 4'd7;
  localparam logic [3:0] OP_LSLA = 4'd8;
  localparam logic [3:0] OP_ASRA = 4'd9;
  localparam logic [3:0] OP_RORA = 4'd10;
  localparam logic [3:0] OP_ROLA = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam int ZeroFlag  = 0;
  localparam int CarryFlag = 1;
  localparam int NegFlag   = 2;
  localparam int OverFlag  = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic is_shift(input logic [3:0] op);
    return op >= OP_LSRA && op <= OP_ROLA;
  endfunction
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: N-cycle unsigned shift-add multiplier
// Ports: clk_i/rst_ni clock and async active-low reset; start_i loads a_i/b_i;
//   last_o marks the final step; prod_o is the product after the current step.
module alu_seq_mul #(
  parameter int N = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           last_o,
  output logic [2*N-1:0] prod_o
);
  localparam int KW = $clog2(N + 1);
  logic [2*N-1:0] p_q, p_d;
  logic [N-1:0] a_q;
  logic [KW-1:0] cnt_q;
  logic [N:0] sum;
  // Upper half accumulates the multiplicand; the lower half holds the
  // remaining multiplier bits and collects product bits as it shifts right.
  always_comb begin
    sum = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_d = {sum, p_q[N-1:1]};
  end
  assign last_o = cnt_q == KW'(1);
  assign prod_o = p_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      p_q   <= '0;
      a_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      p_q   <= {{N{1'b0}}, b_i};
      a_q   <= a_i;
      cnt_q <= KW'(N);
    end else if (cnt_q != '0) begin
      p_q   <= p_d;
      cnt_q <= cnt_q - KW'(1);
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with latched operands, iterative shifts and optional multiply
// Build option: define ALU_SEQ_MUL_EN to build the shift-add multiplier for op 1100.
// Ports: Clk/Reset_N clock and async active-low reset; Start/FuncOp/A/B/Cnt request;
//   FlagsLd/IFlags flag preload; OE_N/Y tri-state result bus; YHi product high half;
//   OFlags {V,N,C,Z}; Busy/Done/Illegal status.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset_N,
  input  logic          Start,
  input  logic [3:0]    FuncOp,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [CW-1:0] Cnt,
  input  logic          FlagsLd,
  input  logic [3:0]    IFlags,
  input  logic          OE_N,
  output tri   [N-1:0]  Y,
  output logic [N-1:0]  YHi,
  output logic [3:0]    OFlags,
  output logic          Busy,
  output logic          Done,
  output logic          Illegal
);
  localparam int KW = $clog2(N + 1);
`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif
  state_e state_q;
  logic [KW-1:0] cnt_q;
  logic [3:0] op_q, flags_q, flags_d, mul_flags;
  logic [N-1:0] a_q, b_q, y_q, yhi_q, bb, a_d, res;
  logic [N:0] sum;
  logic zc_q, busy_q, done_q, illegal_q;
  logic ci, left, sh_out, c_d, v_d, arith, legal, last, is_mul, mul_start, mul_last;
  logic [2*N-1:0] mul_p;
  assign mul_start = state_q == IDLE && Start && FuncOp == OP_MUL;
`ifdef ALU_SEQ_MUL_EN
  alu_seq_mul #(.N(N)) u_mul (
    .clk_i  (Clk),
    .rst_ni (Reset_N),
    .start_i(mul_start),
    .a_i    (A),
    .b_i    (B),
    .last_o (mul_last),
    .prod_o (mul_p)
  );
`else
  assign mul_last = mul_start;
  assign mul_p    = '0;
`endif
  assign is_mul = MulEn && op_q == OP_MUL;
  assign legal  = op_q < OP_MUL || is_mul;
  assign last   = is_mul ? mul_last : cnt_q == KW'(1);
  assign arith  = op_q <= OP_SUBC;
  // One adder serves Add/Sub/Subc: subtraction uses ~B with carry-in 1 (Sub) or ~C (Subc).
  always_comb begin
    bb     = op_q == OP_ADD ? b_q : ~b_q;
    ci     = op_q == OP_ADD ? flags_q[CarryFlag] : op_q == OP_SUB ? 1'b1 : ~flags_q[CarryFlag];
    sum    = {1'b0, a_q} + {1'b0, bb} + (N+1)'(ci);
    left   = op_q == OP_LSLA || op_q == OP_ROLA;
    a_d    = left ? {a_q[N-2:0], op_q == OP_ROLA && a_q[N-1]}
                  : {op_q == OP_RORA ? a_q[0] : op_q == OP_ASRA && a_q[N-1], a_q[N-1:1]};
    sh_out = left ? a_q[N-1] : a_q[0];
    res    = op_q == OP_AND ? a_q & b_q :
             op_q == OP_OR  ? a_q | b_q :
             op_q == OP_NOT ? ~a_q :
             op_q == OP_XOR ? a_q ^ b_q :
             is_shift(op_q) ? (zc_q ? a_q : a_d) : sum[N-1:0];
    c_d    = arith ? sum[N] : is_shift(op_q) ? (zc_q ? flags_q[CarryFlag] : sh_out) : 1'b0;
    v_d    = arith ? (a_q[N-1] ^ sum[N-1]) & ~(a_q[N-1] ^ bb[N-1]) :
             op_q == OP_LSLA && !zc_q ? res[N-1] ^ sh_out : 1'b0;
    flags_d   = {v_d, res[N-1], c_d, res == '0};
    mul_flags = {1'b0, mul_p[2*N-1], |mul_p[2*N-1:N], mul_p == '0};
  end
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      zc_q      <= 1'b0;
      y_q       <= '0;
      yhi_q     <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (FlagsLd) flags_q <= IFlags;
          if (Start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            op_q    <= FuncOp;
            a_q     <= A;
            b_q     <= B;
            zc_q    <= Cnt == '0;
            cnt_q   <= is_shift(FuncOp) && Cnt != '0 ? KW'(Cnt) :
                       MulEn && FuncOp == OP_MUL ? KW'(N) : KW'(1);
          end
        end
        RUN: begin
          cnt_q <= cnt_q - KW'(1);
          if (is_shift(op_q)) a_q <= a_d;
          if (last) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            illegal_q <= !legal;
            if (legal) begin
              y_q     <= is_mul ? mul_p[N-1:0] : res;
              yhi_q   <= is_mul ? mul_p[2*N-1:N] : '0;
              flags_q <= is_mul ? mul_flags : flags_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign Y       = OE_N ? {N{1'bz}} : y_q;
  assign YHi     = yhi_q;
  assign OFlags  = flags_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Illegal = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (N=8)
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flags_ld = 1'b0, oe_n = 1'b0;
  logic [3:0] func_op = '0, iflags = '0;
  logic [7:0] a_in = '0, b_in = '0;
  logic [2:0] cnt = '0;
  wire  [7:0] y;
  logic [7:0] yhi, zz;
  logic [3:0] oflags;
  logic busy, done, illegal;
  int total = 0, bad = 0, lat, bc;
  alu_seq #(.N(8)) dut (
    .Clk(clk), .Reset_N(rst_n), .Start(start), .FuncOp(func_op), .A(a_in), .B(b_in),
    .Cnt(cnt), .FlagsLd(flags_ld), .IFlags(iflags), .OE_N(oe_n), .Y(y), .YHi(yhi),
    .OFlags(oflags), .Busy(busy), .Done(done), .Illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] c, input logic ld, input logic [3:0] fl,
                        input logic poke, output int l, output int n);
    @(negedge clk);
    start = 1'b1; func_op = op; a_in = a; b_in = b; cnt = c; flags_ld = ld; iflags = fl;
    @(negedge clk);
    start = poke; flags_ld = 1'b0; func_op = 4'h0; a_in = 8'h00; b_in = 8'h5A;
    l = 0;
    n = 0;
    while (!done && l < 40) begin
      if (busy) n++;
      @(negedge clk);
      l++;
      if (l == 2) start = 1'b0;
    end
    if (busy) n++;
  endtask
  task automatic exec(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] c, input logic ld,
                      input logic [3:0] fl, input logic poke, input logic [7:0] ey,
                      input logic [7:0] ehi, input logic [3:0] efl, input logic eill,
                      input int elat);
    run_op(op, a, b, c, ld, fl, poke, lat, bc);
    chk({tag, ".lat"}, 16'(lat), 16'(elat));
    chk({tag, ".y"}, {8'h00, y}, {8'h00, ey});
    chk({tag, ".yhi"}, {8'h00, yhi}, {8'h00, ehi});
    chk({tag, ".flags"}, {12'h000, oflags}, {12'h000, efl});
    chk({tag, ".ill"}, {15'h0, illegal}, {15'h0, eill});
    @(negedge clk);
    chk({tag, ".idle"}, {13'h0, done, busy, illegal}, 16'h0000);
  endtask
  initial begin
    zz = 8'hzz;
    #12;
    chk("rst.y", {8'h00, y}, 16'h0000);
    chk("rst.yhi", {8'h00, yhi}, 16'h0000);
    chk("rst.flags", {12'h000, oflags}, 16'h0000);
    chk("rst.status", {13'h0, busy, done, illegal}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exec("add_c", 4'h0, 8'h7F, 8'h00, 3'd0, 1'b1, 4'b0010, 1'b0, 8'h80, 8'h00, 4'b1100, 1'b0, 1);
    exec("subc", 4'h2, 8'h10, 8'h10, 3'd0, 1'b1, 4'b0010, 1'b0, 8'hFF, 8'h00, 4'b0100, 1'b0, 1);
    exec("sub_neg", 4'h1, 8'h10, 8'h20, 3'd0, 1'b0, 4'b0000, 1'b0, 8'hF0, 8'h00, 4'b0100, 1'b0, 1);
    exec("sub_ovf", 4'h1, 8'h80, 8'h01, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h7F, 8'h00, 4'b1010, 1'b0, 1);
    exec("and", 4'h3, 8'hF0, 8'h3C, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h30, 8'h00, 4'b0000, 1'b0, 1);
    exec("xor_z", 4'h6, 8'hAA, 8'hAA, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h00, 4'b0001, 1'b0, 1);
    exec("lsl3", 4'h8, 8'hA5, 8'h00, 3'd3, 1'b0, 4'b0000, 1'b1, 8'h28, 8'h00, 4'b1010, 1'b0, 3);
    chk("lsl3.busy_cycles", 16'(bc), 16'd4);
    exec("ror1", 4'hA, 8'h01, 8'h00, 3'd1, 1'b0, 4'b0000, 1'b0, 8'h80, 8'h00, 4'b0110, 1'b0, 1);
    exec("asr7", 4'h9, 8'h80, 8'h00, 3'd7, 1'b0, 4'b0000, 1'b0, 8'hFF, 8'h00, 4'b0100, 1'b0, 7);
    exec("lsr0", 4'h7, 8'h00, 8'h00, 3'd0, 1'b1, 4'b0010, 1'b0, 8'h00, 8'h00, 4'b0011, 1'b0, 1);
    exec("rol1", 4'hB, 8'h81, 8'h00, 3'd1, 1'b0, 4'b0000, 1'b0, 8'h03, 8'h00, 4'b0010, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
    exec("mul", 4'hC, 8'hFF, 8'hFF, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h01, 8'hFE, 4'b0110, 1'b0, 8);
    exec("ill_e", 4'hE, 8'h55, 8'h55, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h01, 8'hFE, 4'b0110, 1'b1, 1);
`else
    exec("mul_ill", 4'hC, 8'hFF, 8'hFF, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h03, 8'h00, 4'b0010, 1'b1, 1);
    exec("ill_e", 4'hE, 8'h55, 8'h55, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h03, 8'h00, 4'b0010, 1'b1, 1);
`endif
    exec("or", 4'h4, 8'h0F, 8'hF0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'hFF, 8'h00, 4'b0100, 1'b0, 1);
    oe_n = 1'b1;
    #1;
    chk("bus_z", {8'h00, y}, {8'h00, zz});
    oe_n = 1'b0;
    #1;
    chk("bus_on", {8'h00, y}, 16'h00FF);
    @(negedge clk);
    start = 1'b1; func_op = 4'hC; a_in = 8'hFF; b_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.y", {8'h00, y}, 16'h0000);
    chk("arst.yhi", {8'h00, yhi}, 16'h0000);
    chk("arst.flags", {12'h000, oflags}, 16'h0000);
    chk("arst.status", {13'h0, busy, done, illegal}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exec("add_after", 4'h0, 8'h01, 8'h02, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h03, 8'h00, 4'b0000, 1'b0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
